// File: rtl/xif_offload_ctrl_if.sv
// Bundle of the core-side, XIF-side and GPR write-back signals of the offload controller.
// The master modport is the controller; the slave modport is everything around it.
interface xif_offload_ctrl_if #(
  parameter int unsigned XLEN            = 32,
  parameter int unsigned X_ID_WIDTH      = 4,
  parameter int unsigned MAX_OUTSTANDING = 4
);
  localparam int unsigned CntW = $clog2(MAX_OUTSTANDING + 1);

  // Core pipeline side
  logic                  instr_valid_i;
  logic                  instr_ready_o;
  logic [31:0]           instr_i;
  logic [2*XLEN-1:0]     rs_i;
  logic [1:0]            rs_valid_i;
  logic                  kill_i;
  logic                  accepted_o;

  // XIF issue / commit
  logic                  issue_valid_o;
  logic                  issue_ready_i;
  logic [31:0]           issue_instr_o;
  logic [X_ID_WIDTH-1:0] issue_id_o;
  logic [2*XLEN-1:0]     issue_rs_o;
  logic [1:0]            issue_rs_valid_o;
  logic                  issue_accept_i;
  logic                  commit_valid_o;
  logic [X_ID_WIDTH-1:0] commit_id_o;
  logic                  commit_kill_o;

  // XIF result
  logic                  result_valid_i;
  logic                  result_ready_o;
  logic [X_ID_WIDTH-1:0] result_id_i;
  logic [XLEN-1:0]       result_data_i;
  logic [4:0]            result_rd_i;
  logic                  result_we_i;
  logic                  result_err_i;

  // GPR write-back and status
  logic                  gpr_busy_i;
  logic                  gpr_we_o;
  logic [4:0]            gpr_waddr_o;
  logic [XLEN-1:0]       gpr_wdata_o;
  logic                  err_o;
  logic                  spurious_o;
  logic [CntW-1:0]       outstanding_o;

  modport master (
    input  instr_valid_i, instr_i, rs_i, rs_valid_i, kill_i,
    output instr_ready_o, accepted_o,
    output issue_valid_o, issue_instr_o, issue_id_o, issue_rs_o, issue_rs_valid_o,
    input  issue_ready_i, issue_accept_i,
    output commit_valid_o, commit_id_o, commit_kill_o,
    input  result_valid_i, result_id_i, result_data_i, result_rd_i, result_we_i, result_err_i,
    output result_ready_o,
    input  gpr_busy_i,
    output gpr_we_o, gpr_waddr_o, gpr_wdata_o, err_o, spurious_o, outstanding_o
  );

  modport slave (
    output instr_valid_i, instr_i, rs_i, rs_valid_i, kill_i,
    input  instr_ready_o, accepted_o,
    input  issue_valid_o, issue_instr_o, issue_id_o, issue_rs_o, issue_rs_valid_o,
    output issue_ready_i, issue_accept_i,
    input  commit_valid_o, commit_id_o, commit_kill_o,
    output result_valid_i, result_id_i, result_data_i, result_rd_i, result_we_i, result_err_i,
    input  result_ready_o,
    output gpr_busy_i,
    input  gpr_we_o, gpr_waddr_o, gpr_wdata_o, err_o, spurious_o, outstanding_o
  );
endinterface

// File: rtl/xif_offload_ctrl.sv
// Offload controller: issues one instruction at a time over XIF, commits it one cycle after
// an accepted issue, tracks in-flight ids in a scoreboard and writes results back to the GPRs.
module xif_offload_ctrl #(
  parameter int unsigned XLEN            = 32,
  parameter int unsigned X_ID_WIDTH      = 4,
  parameter int unsigned MAX_OUTSTANDING = 4
) (
  input logic                clk_i,
  input logic                rst_ni,
  xif_offload_ctrl_if.master bus
);
  localparam int unsigned NumIds = 2 ** X_ID_WIDTH;
  localparam int unsigned CntW   = $clog2(MAX_OUTSTANDING + 1);
  localparam logic [CntW-1:0] MaxOut = CntW'(MAX_OUTSTANDING);

  typedef enum logic [1:0] {StIdle, StIssue, StCommit} state_e;

  state_e                state_q, state_d;
  logic [31:0]           instr_q;
  logic [2*XLEN-1:0]     rs_q;
  logic [1:0]            rs_valid_q;
  logic [X_ID_WIDTH-1:0] id_q;
  logic [X_ID_WIDTH-1:0] next_id_q, next_id_d;
  logic [NumIds-1:0]     sb_q, sb_d;
  logic [CntW-1:0]       outstanding_q, outstanding_d;

  logic capture, sb_set, kill_clr, issue_valid;
  logic res_hs, res_hit, gpr_we;

  // Result handshake; gated by reset so no write/spurious pulse can leak out while held in reset
  assign res_hs  = bus.result_valid_i & ~bus.gpr_busy_i & rst_ni;
  assign res_hit = res_hs & sb_q[bus.result_id_i];

  // FSM next state and issue/commit outputs
  always_comb begin
    state_d            = state_q;
    capture            = 1'b0;
    sb_set             = 1'b0;
    kill_clr           = 1'b0;
    issue_valid        = 1'b0;
    bus.instr_ready_o  = 1'b0;
    bus.accepted_o     = 1'b0;
    bus.commit_valid_o = 1'b0;
    bus.commit_id_o    = '0;
    bus.commit_kill_o  = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (bus.instr_valid_i && (outstanding_q < MaxOut) && !sb_q[next_id_q]) begin
          state_d = StIssue;
          capture = 1'b1;
        end
      end
      StIssue: begin
        issue_valid = 1'b1;
        if (bus.issue_ready_i) begin
          bus.instr_ready_o = 1'b1;
          bus.accepted_o    = bus.issue_accept_i;
          if (bus.issue_accept_i) begin
            state_d = StCommit;
            sb_set  = 1'b1;
          end else begin
            state_d = StIdle;
          end
        end
      end
      StCommit: begin
        bus.commit_valid_o = 1'b1;
        bus.commit_id_o    = id_q;
        bus.commit_kill_o  = bus.kill_i;
        kill_clr           = bus.kill_i;
        state_d            = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  // Issue payload is only visible while issue_valid_o is high
  always_comb begin
    bus.issue_valid_o    = issue_valid;
    bus.issue_instr_o    = issue_valid ? instr_q : '0;
    bus.issue_id_o       = issue_valid ? id_q : '0;
    bus.issue_rs_o       = issue_valid ? rs_q : '0;
    bus.issue_rs_valid_o = issue_valid ? rs_valid_q : '0;
  end

  // Scoreboard update, id allocation and in-flight count
  always_comb begin
    sb_d      = sb_q;
    next_id_d = next_id_q;
    if (sb_set) begin
      sb_d[id_q] = 1'b1;
      next_id_d  = next_id_q + 1'b1;
    end
    if (kill_clr) sb_d[id_q] = 1'b0;
    // The issue guard keeps set and result-clear on distinct ids
    if (res_hit) sb_d[bus.result_id_i] = 1'b0;
    outstanding_d = '0;
    for (int i = 0; i < int'(NumIds); i++) begin
      outstanding_d = outstanding_d + CntW'(sb_d[i]);
    end
  end

  // GPR write-back and result status pulses
  always_comb begin
    gpr_we             = res_hit & bus.result_we_i & ~bus.result_err_i;
    bus.result_ready_o = ~bus.gpr_busy_i;
    bus.gpr_we_o       = gpr_we;
    bus.gpr_waddr_o    = gpr_we ? bus.result_rd_i : '0;
    bus.gpr_wdata_o    = gpr_we ? bus.result_data_i : '0;
    bus.err_o          = res_hit & bus.result_err_i;
    bus.spurious_o     = res_hs & ~sb_q[bus.result_id_i];
    bus.outstanding_o  = outstanding_q;
  end

  // State, scoreboard and payload registers
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q       <= StIdle;
      instr_q       <= '0;
      rs_q          <= '0;
      rs_valid_q    <= '0;
      id_q          <= '0;
      next_id_q     <= '0;
      sb_q          <= '0;
      outstanding_q <= '0;
    end else begin
      state_q       <= state_d;
      next_id_q     <= next_id_d;
      sb_q          <= sb_d;
      outstanding_q <= outstanding_d;
      if (capture) begin
        instr_q    <= bus.instr_i;
        rs_q       <= bus.rs_i;
        rs_valid_q <= bus.rs_valid_i;
        id_q       <= next_id_q;
      end
    end
  end
endmodule

// File: tb/tb_xif_offload_ctrl.sv
// Directed bench for xif_offload_ctrl: a per-cycle vector table plus a hand-written
// asynchronous-reset sequence.
module tb_xif_offload_ctrl;
  localparam int unsigned XLEN = 32;
  localparam int unsigned IDW  = 4;
  localparam int unsigned MAXO = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  xif_offload_ctrl_if #(.XLEN(XLEN), .X_ID_WIDTH(IDW), .MAX_OUTSTANDING(MAXO)) bus ();

  xif_offload_ctrl #(.XLEN(XLEN), .X_ID_WIDTH(IDW), .MAX_OUTSTANDING(MAXO)) dut (
    .clk_i (clk),
    .rst_ni(rst_n),
    .bus   (bus)
  );

  typedef struct packed {
    logic        rst_n;
    logic        iv;
    logic [31:0] instr;
    logic        ir;
    logic        acc;
    logic        kill;
    logic        rv;
    logic [3:0]  rid;
    logic [4:0]  rd;
    logic [31:0] data;
    logic        we;
    logic        err;
    logic        busy;
  } in_t;

  typedef struct packed {
    logic        instr_ready;
    logic        accepted;
    logic        issue_valid;
    logic [3:0]  issue_id;
    logic [31:0] issue_instr;
    logic [1:0]  issue_rs_valid;
    logic [63:0] issue_rs;
    logic        commit_valid;
    logic [3:0]  commit_id;
    logic        commit_kill;
    logic        result_ready;
    logic        gpr_we;
    logic [4:0]  waddr;
    logic [31:0] wdata;
    logic        err;
    logic        spurious;
    logic [2:0]  outstanding;
  } out_t;

  typedef struct packed {
    in_t  i;
    out_t e;
  } vec_t;

  vec_t tbl[$];
  int   nvec  = 0;
  int   nfail = 0;

  // ---- stimulus constructors
  function automatic in_t i_none();
    in_t v = '0;
    v.rst_n = 1'b1;
    return v;
  endfunction
  function automatic in_t i_rst();
    return '0;
  endfunction
  function automatic in_t i_iv(input logic [31:0] instr);
    in_t v = i_none();
    v.iv = 1'b1; v.instr = instr;
    return v;
  endfunction
  function automatic in_t i_wait(input logic [31:0] instr);
    return i_iv(instr);
  endfunction
  function automatic in_t i_hs(input logic [31:0] instr, input logic acc);
    in_t v = i_iv(instr);
    v.ir = 1'b1; v.acc = acc;
    return v;
  endfunction
  function automatic in_t i_kill();
    in_t v = i_none();
    v.kill = 1'b1;
    return v;
  endfunction
  function automatic in_t res(input in_t b, input logic [3:0] rid, input logic [4:0] rd,
                              input logic [31:0] data, input logic we, input logic err,
                              input logic busy);
    in_t v = b;
    v.rv = 1'b1; v.rid = rid; v.rd = rd; v.data = data; v.we = we; v.err = err; v.busy = busy;
    return v;
  endfunction

  // ---- expectation constructors
  function automatic out_t e_none(input logic [2:0] n);
    out_t o = '0;
    o.result_ready = 1'b1;
    o.outstanding  = n;
    return o;
  endfunction
  function automatic out_t e_iss(input logic [3:0] id, input logic [31:0] instr, input logic hs,
                                 input logic acc, input logic [2:0] n);
    out_t o = e_none(n);
    o.issue_valid    = 1'b1;
    o.issue_id       = id;
    o.issue_instr    = instr;
    o.issue_rs_valid = 2'b11;
    o.issue_rs       = {instr, ~instr};
    o.instr_ready    = hs;
    o.accepted       = hs & acc;
    return o;
  endfunction
  function automatic out_t e_cmt(input logic [3:0] id, input logic kill, input logic [2:0] n);
    out_t o = e_none(n);
    o.commit_valid = 1'b1;
    o.commit_id    = id;
    o.commit_kill  = kill;
    return o;
  endfunction
  function automatic out_t w_gpr(input out_t b, input logic [4:0] rd, input logic [31:0] data);
    out_t o = b;
    o.gpr_we = 1'b1; o.waddr = rd; o.wdata = data;
    return o;
  endfunction
  function automatic out_t e_err(input out_t b);
    out_t o = b;
    o.err = 1'b1;
    return o;
  endfunction
  function automatic out_t e_spur(input out_t b);
    out_t o = b;
    o.spurious = 1'b1;
    return o;
  endfunction
  function automatic out_t e_busy(input out_t b);
    out_t o = b;
    o.result_ready = 1'b0;
    return o;
  endfunction

  function automatic void add(input in_t i, input out_t e);
    vec_t v;
    v.i = i; v.e = e;
    tbl.push_back(v);
  endfunction

  task automatic apply(input in_t v);
    rst_n              = v.rst_n;
    bus.instr_valid_i  = v.iv;
    bus.instr_i        = v.instr;
    bus.rs_i           = {v.instr, ~v.instr};
    bus.rs_valid_i     = v.iv ? 2'b11 : 2'b00;
    bus.kill_i         = v.kill;
    bus.issue_ready_i  = v.ir;
    bus.issue_accept_i = v.acc;
    bus.result_valid_i = v.rv;
    bus.result_id_i    = v.rid;
    bus.result_rd_i    = v.rd;
    bus.result_data_i  = v.data;
    bus.result_we_i    = v.we;
    bus.result_err_i   = v.err;
    bus.gpr_busy_i     = v.busy;
  endtask

  function automatic out_t sample();
    out_t o;
    o.instr_ready    = bus.instr_ready_o;
    o.accepted       = bus.accepted_o;
    o.issue_valid    = bus.issue_valid_o;
    o.issue_id       = bus.issue_id_o;
    o.issue_instr    = bus.issue_instr_o;
    o.issue_rs_valid = bus.issue_rs_valid_o;
    o.issue_rs       = bus.issue_rs_o;
    o.commit_valid   = bus.commit_valid_o;
    o.commit_id      = bus.commit_id_o;
    o.commit_kill    = bus.commit_kill_o;
    o.result_ready   = bus.result_ready_o;
    o.gpr_we         = bus.gpr_we_o;
    o.waddr          = bus.gpr_waddr_o;
    o.wdata          = bus.gpr_wdata_o;
    o.err            = bus.err_o;
    o.spurious       = bus.spurious_o;
    o.outstanding    = bus.outstanding_o;
    return o;
  endfunction

  task automatic check(input string name, input out_t e);
    out_t got = sample();
    nvec++;
    if (got !== e) begin
      nfail++;
      $display("FAIL %s: got %h expected %h", name, got, e);
    end
  endtask

  // A same-id set and clear would need a result hitting the id being accepted; that id is
  // never outstanding, so such a result must be reported as spurious.
  always @(negedge clk) begin
    if (rst_n && bus.issue_valid_o && bus.issue_ready_i && bus.issue_accept_i &&
        bus.result_valid_i && bus.result_ready_o && bus.result_id_i == bus.issue_id_o) begin
      assert (bus.spurious_o && !bus.gpr_we_o)
      else $error("same-id set/clear not flagged spurious");
    end
  end

  localparam logic [31:0] IB = 32'h0000_0B13;
  localparam logic [31:0] IA = 32'h0000_0A13;
  localparam logic [31:0] IC = 32'h0000_0C13;
  localparam logic [31:0] ID = 32'h0000_0D00;
  localparam logic [31:0] I4 = 32'h0000_0E13;
  localparam logic [31:0] I5 = 32'h0000_0F13;

  initial begin
    apply(i_rst());

    // Rejected issue after a 3-cycle ready stall; next_id must stay 0
    add(i_rst(), e_none(0));
    add(i_iv(IB), e_none(0));
    for (int k = 0; k < 3; k++) add(i_wait(IB), e_iss(4'd0, IB, 1'b0, 1'b0, 3'd0));
    add(i_hs(IB, 1'b0), e_iss(4'd0, IB, 1'b1, 1'b0, 3'd0));
    add(i_none(), e_none(0));
    // Single accepted instruction, commit, write-back
    add(i_iv(IA), e_none(0));
    add(i_hs(IA, 1'b1), e_iss(4'd0, IA, 1'b1, 1'b1, 3'd0));
    add(i_none(), e_cmt(4'd0, 1'b0, 3'd1));
    add(res(i_none(), 4'd0, 5'd5, 32'hDEAD_BEEF, 1'b1, 1'b0, 1'b0),
        w_gpr(e_none(1), 5'd5, 32'hDEAD_BEEF));
    add(i_none(), e_none(0));
    // Killed at commit; its later result is spurious
    add(i_iv(IC), e_none(0));
    add(i_hs(IC, 1'b1), e_iss(4'd1, IC, 1'b1, 1'b1, 3'd0));
    add(i_kill(), e_cmt(4'd1, 1'b1, 3'd1));
    add(res(i_none(), 4'd1, 5'd7, 32'h1234_5678, 1'b1, 1'b0, 1'b0), e_spur(e_none(0)));
    add(i_none(), e_none(0));
    // Fill to the outstanding limit, stall, retire id 1, then issue id 4
    add(i_rst(), e_none(0));
    add(i_none(), e_none(0));
    for (int k = 0; k < 4; k++) begin
      add(i_iv(ID + 32'(k)), e_none(3'(k)));
      add(i_hs(ID + 32'(k), 1'b1), e_iss(4'(k), ID + 32'(k), 1'b1, 1'b1, 3'(k)));
      add(i_none(), e_cmt(4'(k), 1'b0, 3'(k + 1)));
    end
    add(i_iv(I4), e_none(4));
    add(i_iv(I4), e_none(4));
    add(res(i_iv(I4), 4'd1, 5'd9, 32'hA5A5_0001, 1'b1, 1'b0, 1'b0),
        w_gpr(e_none(4), 5'd9, 32'hA5A5_0001));
    add(i_iv(I4), e_none(3));
    add(i_hs(I4, 1'b1), e_iss(4'd4, I4, 1'b1, 1'b1, 3'd3));
    add(i_none(), e_cmt(4'd4, 1'b0, 3'd4));
    // GPR port busy, then released; error result
    add(res(i_none(), 4'd0, 5'd3, 32'h0BAD_F00D, 1'b1, 1'b0, 1'b1), e_busy(e_none(4)));
    add(res(i_none(), 4'd0, 5'd3, 32'h0BAD_F00D, 1'b1, 1'b0, 1'b0),
        w_gpr(e_none(4), 5'd3, 32'h0BAD_F00D));
    add(res(i_none(), 4'd2, 5'd4, 32'h1111_2222, 1'b1, 1'b1, 1'b0), e_err(e_none(3)));
    // Accept id 5 while retiring id 3 in the same cycle: count must stay at 2
    add(i_iv(I5), e_none(2));
    add(res(i_hs(I5, 1'b1), 4'd3, 5'd6, 32'h0000_0066, 1'b1, 1'b0, 1'b0),
        w_gpr(e_iss(4'd5, I5, 1'b1, 1'b1, 3'd2), 5'd6, 32'h0000_0066));
    add(i_none(), e_cmt(4'd5, 1'b0, 3'd2));
    add(res(i_none(), 4'd4, 5'd1, 32'h0000_0077, 1'b0, 1'b0, 1'b0), e_none(2));
    add(res(i_none(), 4'd5, 5'd31, 32'hFFFF_FFFF, 1'b1, 1'b0, 1'b0),
        w_gpr(e_none(1), 5'd31, 32'hFFFF_FFFF));
    add(i_none(), e_none(0));

    foreach (tbl[k]) begin
      @(negedge clk);
      apply(tbl[k].i);
      #1;
      check($sformatf("vec%0d", k), tbl[k].e);
    end

    // Asynchronous reset in the middle of an ISSUE with one id outstanding
    @(negedge clk); apply(i_iv(32'h0000_1013));
    @(negedge clk); apply(i_hs(32'h0000_1013, 1'b1));
    #1 check("hand_issue_id6", e_iss(4'd6, 32'h0000_1013, 1'b1, 1'b1, 3'd0));
    @(negedge clk); apply(i_none());
    #1 check("hand_commit_id6", e_cmt(4'd6, 1'b0, 3'd1));
    @(negedge clk); apply(i_iv(32'h0000_1113));
    #1 check("hand_idle", e_none(1));
    @(negedge clk); apply(i_wait(32'h0000_1113));
    #1 check("mid_issue_id7", e_iss(4'd7, 32'h0000_1113, 1'b0, 1'b0, 3'd1));
    #2 rst_n = 1'b0;
    #1 check("async_reset", e_none(0));
    @(negedge clk); apply(i_iv(32'h0000_1213));
    #1 check("post_reset_no_commit", e_none(0));
    @(negedge clk); apply(i_hs(32'h0000_1213, 1'b1));
    #1 check("post_reset_id0", e_iss(4'd0, 32'h0000_1213, 1'b1, 1'b1, 3'd0));
    @(negedge clk); apply(i_none());
    #1 check("post_reset_commit", e_cmt(4'd0, 1'b0, 3'd1));

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
    $finish;
  end
endmodule
